// File: rtl/main_slave_host_bridge.sv
// rtl/main_slave_host_bridge.sv - host initiator for the HLS core slave memory port and start/done handshake
// One command in flight at a time: memory access on channel 0, or a timed start/done run.
module main_slave_host_bridge #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int SIZE_W     = 7,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 200000000
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           cmd_valid,
  output logic                                           cmd_ready,
  input  logic [1:0]                                     cmd_op,
  input  logic [ADDR_W-1:0]                              cmd_addr,
  input  logic [SIZE_W-1:0]                              cmd_size,
  input  logic [DATA_W-1:0]                              cmd_wdata,
  output logic                                           rsp_valid,
  input  logic                                           rsp_ready,
  output logic [((CNT_W > DATA_W) ? CNT_W : DATA_W)-1:0] rsp_data,
  output logic                                           rsp_err,
  output logic                                           start_port,
  input  logic                                           done_port,
  output logic [1:0]                                     S_oe_ram,
  output logic [1:0]                                     S_we_ram,
  output logic [2*ADDR_W-1:0]                            S_addr_ram,
  output logic [2*DATA_W-1:0]                            S_Wdata_ram,
  output logic [2*SIZE_W-1:0]                            S_data_ram_size,
  input  logic [2*DATA_W-1:0]                            Sout_Rdata_ram,
  input  logic [1:0]                                     Sout_DataRdy
);

  localparam int RSP_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;
  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;
  localparam bit               TMO_EN   = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [RSP_W-1:0] TMO_DATA = RSP_W'(MAX_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_MEM, S_START, S_RUN, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               init_q;
  logic [1:0]         op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [SIZE_W-1:0]  size_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic [CNT_W-1:0]   dwell_q;
  logic [RSP_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic [DATA_W-1:0]  size_mask;
  logic               accept, tmo, mem_act;

  logic unused_inputs;
  assign unused_inputs = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  assign accept  = cmd_valid && init_q && (state_q == S_IDLE);
  assign tmo     = TMO_EN && (dwell_q == TMO_LAST);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign mem_act = (state_q == S_MEM);

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      size_mask[i] = (i < int'(size_q));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_WRITE, OP_READ: state_d = S_MEM;
            OP_RUN:            state_d = S_START;
            default:           state_d = S_RESP;
          endcase
        end
      end
      S_MEM:   if (Sout_DataRdy[0] || tmo) state_d = S_RESP;
      S_START: state_d = done_port ? S_RESP : S_RUN;
      S_RUN:   if (done_port || tmo) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: command capture, cycle/dwell counters and the response latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      init_q     <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      dwell_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            addr_q  <= cmd_addr;
            size_q  <= cmd_size;
            wdata_q <= cmd_wdata;
            dwell_q <= '0;
            if (cmd_op == 2'd3) begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        S_MEM: begin
          dwell_q <= dwell_q + CNT_W'(1);
          if (Sout_DataRdy[0]) begin
            rsp_err_q  <= 1'b0;
            rsp_data_q <= (op_q == OP_READ) ? RSP_W'(Sout_Rdata_ram[DATA_W-1:0] & size_mask) : '0;
          end else if (tmo) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= TMO_DATA;
          end
        end
        S_START: begin
          cnt_q   <= CNT_W'(1);
          dwell_q <= '0;
          if (done_port) begin
            rsp_err_q  <= 1'b0;
            rsp_data_q <= RSP_W'(1);
          end
        end
        S_RUN: begin
          // cnt_inc counts the start cycle too, so done in RUN cycle k reports k+1.
          cnt_q   <= cnt_inc;
          dwell_q <= dwell_q + CNT_W'(1);
          if (done_port) begin
            rsp_err_q  <= 1'b0;
            rsp_data_q <= RSP_W'(cnt_inc);
          end else if (tmo) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= TMO_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready       = (state_q == S_IDLE) && init_q;
    rsp_valid       = (state_q == S_RESP);
    rsp_data        = rsp_data_q;
    rsp_err         = rsp_err_q;
    start_port      = (state_q == S_START);
    S_we_ram        = {1'b0, mem_act && (op_q == OP_WRITE)};
    S_oe_ram        = {1'b0, mem_act && (op_q == OP_READ)};
    S_addr_ram      = {{ADDR_W{1'b0}}, mem_act ? addr_q : {ADDR_W{1'b0}}};
    S_Wdata_ram     = {{DATA_W{1'b0}}, mem_act ? wdata_q : {DATA_W{1'b0}}};
    S_data_ram_size = {{SIZE_W{1'b0}}, mem_act ? size_q : {SIZE_W{1'b0}}};
  end

endmodule

// File: tb/tb_main_slave_host_bridge.sv
// tb/tb_main_slave_host_bridge.sv - randomized self-checking bench for main_slave_host_bridge
module tb_main_slave_host_bridge;

  localparam int MAXC = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_addr;
  logic [6:0]   cmd_size;
  logic [63:0]  cmd_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic         rsp_err;
  logic         start_port;
  logic         done_port;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [15:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  main_slave_host_bridge #(.ADDR_W(8), .DATA_W(64), .SIZE_W(7), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] size_mask(input int sz);
    if (sz >= 64) return '1;
    return (64'd1 << sz) - 64'd1;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] addr, input int size, input logic [63:0] wdata);
    int n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    check_eq("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_size = 7'(size); cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = 8'($urandom); cmd_size = 7'($urandom);
    cmd_wdata = rnd64();
  endtask

  task automatic finish_rsp(input logic [63:0] exp_data, input logic exp_err, input int hold);
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_data", rsp_data, exp_data);
    check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
    check_eq("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      tick();
      check_eq("hold_valid", 64'(rsp_valid), 64'd1);
      check_eq("hold_data", rsp_data, exp_data);
      check_eq("hold_err", 64'(rsp_err), 64'(exp_err));
      check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check_eq("cmd_ready_back", 64'(cmd_ready), 64'd1);
  endtask

  // Channel-0 memory responder: DataRdy in the lat-th enabled cycle.
  task automatic mem_op(input bit is_read, input logic [7:0] addr, input int size, input logic [63:0] wdata,
                        input logic [63:0] rdata, input int lat, input int hold);
    int en = 0;
    int n = 0;
    bit err;
    logic [63:0] exp;
    send(is_read ? 2'd1 : 2'd0, addr, size, wdata);
    while (n < MAXC + 8) begin
      if (!(S_we_ram[0] || S_oe_ram[0])) break;
      en++;
      check_eq("en_sel", 64'({S_we_ram, S_oe_ram}), is_read ? 64'b0001 : 64'b0100);
      check_eq("addr", 64'(S_addr_ram), 64'(addr));
      check_eq("size", 64'(S_data_ram_size), 64'(size));
      if (!is_read) check_eq("wdata", S_Wdata_ram[63:0], wdata);
      check_eq("wdata_hi", S_Wdata_ram[127:64], 64'd0);
      Sout_Rdata_ram = {rnd64(), (en == lat) ? rdata : rnd64()};
      Sout_DataRdy   = {1'($urandom), en == lat};
      done_port      = 1'($urandom);
      tick();
      n++;
    end
    Sout_DataRdy = 2'b00;
    done_port    = 1'b0;
    err = (lat > MAXC);
    check_eq("en_cycles", 64'(en), 64'(err ? MAXC : lat));
    exp = err ? 64'(MAXC) : (is_read ? (rdata & size_mask(size)) : 64'd0);
    finish_rsp(exp, err, hold);
  endtask

  // Core model: done_port goes high d cycles after the start cycle and stays high.
  task automatic run_op(input int d, input int hold);
    int c = 0;
    int starts = 0;
    int first = -1;
    bit err;
    send(2'd2, 8'($urandom), 8, rnd64());
    while (!rsp_valid && c < MAXC + 10) begin
      if (start_port) begin
        starts++;
        if (first < 0) first = c;
      end
      done_port    = (c >= d);
      Sout_DataRdy = 2'($urandom);
      tick();
      c++;
    end
    done_port    = 1'b0;
    Sout_DataRdy = 2'b00;
    err = (d > MAXC);
    check_eq("start_pulses", 64'(starts), 64'd1);
    check_eq("start_cycle", 64'(first), 64'd0);
    check_eq("run_latency", 64'(c), 64'(err ? MAXC + 1 : d + 1));
    finish_rsp(err ? 64'(MAXC) : 64'(d + 1), err, hold);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq(tag, {S_oe_ram, S_we_ram, 1'(|S_addr_ram), 1'(|S_Wdata_ram), 1'(|S_data_ram_size),
                   start_port, rsp_valid, rsp_err, cmd_ready, 1'(|rsp_data)}, 64'd0);
  endtask

  initial begin
    int sizes[4] = '{8, 16, 32, 64};
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; done_port = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0;
    #1;
    check_idle_outputs("reset_outputs_t0");
    repeat (3) tick();
    check_idle_outputs("reset_outputs");
    reset = 1'b1;
    #2;
    check_eq("cmd_ready_pre_clk", 64'(cmd_ready), 64'd0);
    tick();
    check_eq("cmd_ready_post_clk", 64'(cmd_ready), 64'd1);

    mem_op(1'b0, 8'h10, 32, 64'hDEADBEEF, 64'h0, 1, 0);
    mem_op(1'b1, 8'h10, 16, 64'h0, 64'h1234_5678_9ABC_BEEF, 2, 0);
    run_op(57, 0);
    run_op(1000, 0);
    run_op(0, 1);
    run_op(MAXC - 1, 0);
    mem_op(1'b1, 8'h22, 64, 64'h0, rnd64(), MAXC + 1, 0);
    mem_op(1'b1, 8'h33, 8, 64'h0, 64'hFFFF_FFFF_FFFF_FFA5, 1, 5);
    send(2'd3, 8'h44, 8, rnd64());
    finish_rsp(64'd0, 1'b1, 2);

    for (int it = 0; it < 40; it++) begin
      int kind = $urandom_range(0, 9);
      int hold = $urandom_range(0, 3);
      if (kind < 4) begin
        int lat = ($urandom_range(0, 9) == 0) ? MAXC + 1 : $urandom_range(1, 5);
        mem_op(kind[0], 8'($urandom), sizes[$urandom_range(0, 3)], rnd64(), rnd64(), lat, hold);
      end else if (kind < 9) begin
        int d = $urandom_range(0, MAXC + 6);
        if (d == MAXC) d = MAXC + 1;
        run_op(d, hold);
      end else begin
        send(2'd3, 8'($urandom), 8, rnd64());
        finish_rsp(64'd0, 1'b1, hold);
      end
    end

    send(2'd1, 8'h55, 32, 64'h0);
    tick();
    tick();
    check_eq("oe_before_reset", 64'(S_oe_ram), 64'b01);
    #2;
    reset = 1'b0;
    #1;
    check_eq("oe_async_drop", 64'(S_oe_ram), 64'd0);
    check_idle_outputs("mid_reset_outputs");
    tick();
    reset = 1'b1;
    #2;
    check_eq("cmd_ready_after_rel", 64'(cmd_ready), 64'd0);
    tick();
    check_eq("cmd_ready_first_clk", 64'(cmd_ready), 64'd1);
    mem_op(1'b1, 8'h10, 32, 64'h0, 64'hCAFE_F00D_1234_5678, 3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
